dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU data-memory request interface (enable/wr/addr/data_in -> data_out).
- Replaces the zero-wait single-cycle memory with a fixed-latency responder, for moving the core to stall-capable memory.
- Accepts one request at a time, holds busy while servicing, and pulses data_valid once when the response (read data or write acknowledge) is ready.

Parameters:
- LATENCY, 4, cycles from acceptance edge to response; legal range 1..15.
- ADDR_W, 10, implemented word-address bits; storage = 2**ADDR_W 16-bit words.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; one clock domain (clk) only
- enable  in  1  request strobe
- wr  in  1  1 = write, 0 = read; sampled only with enable
- addr  in  16  word address; bits [15:ADDR_W] ignored (aliasing)
- data_in  in  16  write data
- data_out  out  16  read data, held until next read response
- data_valid  out  1  one-cycle response pulse, reads and writes
- busy  out  1  request in flight; enable ignored while high
- req_dropped  out  1  one-cycle pulse: enable seen while busy

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0, data_out=0, data_valid=0, busy=0, req_dropped=0. Array contents are not cleared and are retained across reset.
- Acceptance: enable=1 and busy=0 at a rising edge (edge E0).
  - Captures wr and addr[ADDR_W-1:0].
  - Write: array[addr] <= data_in at E0.
  - Read: array[addr] is latched into an internal read register at E0.
- States:
  - IDLE: busy=0. On accept: if LATENCY=1 go RESP, else go WAIT with cnt=LATENCY-2.
  - WAIT: busy=1. Decrement cnt each edge; go RESP when cnt=0 at an edge.
  - RESP: busy=0, data_valid=1 for exactly this cycle. data_out is updated from the read register on entry, reads only; writes leave data_out unchanged.
    - Accept in RESP behaves exactly as accept in IDLE (back-to-back requests).
    - With no new request, go IDLE.
- Timing: data_valid is high in the cycle between edges E(LATENCY-1) and E(LATENCY). LATENCY=1 gives data_valid in the cycle immediately after acceptance.
- Throughput: one request per LATENCY cycles.
- enable=1 while busy=1: request discarded, no array change, req_dropped=1 next cycle; FSM unaffected.
- Hazards: a read following a write to the same address returns the new value, because the write commits at its acceptance edge.
- rst asserted mid-request: FSM returns to IDLE, and no data_valid is produced for the aborted request.
  - A write accepted before reset stays committed.
  - A pending read's data is discarded.
- rst and enable in the same cycle: rst wins, request not accepted, array not written.
- Address wrap: addr=16'h0400 with ADDR_W=10 accesses word 0.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - DATA_W=16 and the LATENCY legal-range constants
- One sub-module: mem_array_sp, a single-port synchronous RAM (write-enable, registered read), instanced once.
- FSM, counter and response registers stay in dmem_responder.

Test Plan (LATENCY=4, ADDR_W=10):
- Write 16'hBEEF to 0x0010 (edge E0) -> busy high E0..E3, data_valid high E3..E4 only, data_out unchanged.
- Read 0x0010 after the above -> data_out=16'hBEEF with data_valid exactly 4 cycles after acceptance.
- Write 0x0020 = 16'h1234, then read 0x0020 accepted in the RESP cycle (back-to-back) -> second data_valid 4 cycles later, data_out=16'h1234, no idle gap.
- During a busy read, pulse enable with wr=1 to 0x0030 = 16'hDEAD -> req_dropped one cycle, later read of 0x0030 does not return 16'hDEAD, first read response unaffected.
- Accept a read of 0x0010, assert rst at E2 -> no data_valid, busy=0, data_out=0 after reset edge. A write accepted before rst persists: re-read 0x0010 returns 16'hBEEF.
- Write 16'h5A5A to addr 16'h0401, read addr 16'h0001 -> 16'h5A5A (aliasing). Repeat both with LATENCY=1 -> data_valid in the cycle right after each acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package mem_pkg;

  localparam int DATA_W  = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory request/response bus between the core and the responder.
interface dmem_responder_if;
  import mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [15:0]       addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              req_dropped;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy, req_dropped
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy, req_dropped
  );
endinterface

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM: write-enable, registered read that holds until the next read.
module mem_array_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset on purpose -- contents must survive rst, and a
  // reset would stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request in flight, busy while servicing,
// a single data_valid pulse per accepted request.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              req_dropped_q, req_dropped_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              accept;
  logic              unused_addr_hi;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  assign busy   = (state_q == WAIT);
  // rst wins over a same-cycle request, so neither the FSM nor the array sees it.
  assign accept = bus.enable && !busy && !rst;

  // Upper address bits alias onto the implemented words.
  assign unused_addr_hi = ^bus.addr[15:ADDR_W];

  mem_array_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (accept && bus.wr),
    .re_i    (accept && !bus.wr),
    .addr_i  (bus.addr[ADDR_W-1:0]),
    .wdata_i (bus.data_in),
    .rdata_o (ram_rdata)
  );

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_rd_d       = op_rd_q;
    data_out_d    = data_out_q;
    req_dropped_d = bus.enable && busy;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP && op_rd_q) data_out_d = ram_rdata;
        if (accept) begin
          op_rd_d = !bus.wr;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_rd_q       <= 1'b0;
      data_out_q    <= '0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_rd_q       <= op_rd_d;
      data_out_q    <= data_out_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  // The read register already holds the word during RESP; it is forwarded then
  // and captured into data_out_q for the cycles that follow.
  assign bus.data_out    = (state_q == RESP && op_rd_q) ? ram_rdata : data_out_q;
  assign bus.data_valid  = (state_q == RESP);
  assign bus.busy        = busy;
  assign bus.req_dropped = req_dropped_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=4 and LATENCY=1 (ADDR_W=10).
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.LATENCY(4), .ADDR_W(10)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  dmem_responder #(.LATENCY(1), .ADDR_W(10)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

  logic [1:0]  en  = '0;
  logic [1:0]  wrv = '0;
  logic [15:0] ad [2];
  logic [15:0] dt [2];
  logic [1:0]  dv, bsy, drop;
  logic [15:0] dout [2];

  assign a_if.enable  = en[0];
  assign a_if.wr      = wrv[0];
  assign a_if.addr    = ad[0];
  assign a_if.data_in = dt[0];
  assign b_if.enable  = en[1];
  assign b_if.wr      = wrv[1];
  assign b_if.addr    = ad[1];
  assign b_if.data_in = dt[1];

  assign dv[0]   = a_if.data_valid;
  assign dv[1]   = b_if.data_valid;
  assign bsy[0]  = a_if.busy;
  assign bsy[1]  = b_if.busy;
  assign drop[0] = a_if.req_dropped;
  assign drop[1] = b_if.req_dropped;
  assign dout[0] = a_if.data_out;
  assign dout[1] = b_if.data_out;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns in the cycle after that edge.
  task automatic issue(input int s, input logic w, input logic [15:0] a, input logic [15:0] d);
    en[s]  = 1'b1;
    wrv[s] = w;
    ad[s]  = a;
    dt[s]  = d;
    step();
    en[s]  = 1'b0;
  endtask

  // Issue, wait (bounded) for data_valid, check edges-to-response and data_out.
  // Returns inside the response cycle so the caller can chain a back-to-back request.
  task automatic xact(input string tag, input int s, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp_do, input int exp_lat);
    int k;
    issue(s, w, a, d);
    k = 0;
    while (!dv[s] && k < 20) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_data_out"}, 32'(dout[s]), 32'(exp_do));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    ad[0] = '0; dt[0] = '0; ad[1] = '0; dt[1] = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_valid", 32'(dv[0]), 32'd0);
    check("rst_data_out", 32'(dout[0]), 32'd0);
    check("rst_dropped", 32'(drop[0]), 32'd0);

    // Write timing: busy after E0..E2, data_valid only between E3 and E4.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    check("wr_busy_e0", 32'(bsy[0]), 32'd1);
    check("wr_valid_e0", 32'(dv[0]), 32'd0);
    step();
    check("wr_busy_e1", 32'(bsy[0]), 32'd1);
    step();
    check("wr_busy_e2", 32'(bsy[0]), 32'd1);
    step();
    check("wr_busy_e3", 32'(bsy[0]), 32'd0);
    check("wr_valid_e3", 32'(dv[0]), 32'd1);
    check("wr_data_out_kept", 32'(dout[0]), 32'd0);
    step();
    check("wr_valid_e4", 32'(dv[0]), 32'd0);

    xact("rd_beef", 0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3);
    step();
    check("rd_pulse_once", 32'(dv[0]), 32'd0);
    check("rd_data_held", 32'(dout[0]), 32'hBEEF);

    // Back-to-back: write then a read accepted in the write's RESP cycle.
    xact("b2b_wr", 0, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 3);
    xact("b2b_rd", 0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3);
    step();
    check("b2b_idle", 32'(dv[0]), 32'd0);

    // Dropped write during a busy read.
    xact("init_30", 0, 1'b1, 16'h0030, 16'h0000, 16'h1234, 3);
    step();
    issue(0, 1'b0, 16'h0010, 16'h0000);
    issue(0, 1'b1, 16'h0030, 16'hDEAD);
    check("drop_pulse", 32'(drop[0]), 32'd1);
    check("drop_busy", 32'(bsy[0]), 32'd1);
    step();
    check("drop_once", 32'(drop[0]), 32'd0);
    step();
    check("drop_rd_valid", 32'(dv[0]), 32'd1);
    check("drop_rd_data", 32'(dout[0]), 32'hBEEF);
    step();
    xact("rd_30", 0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 3);
    step();

    // Reset mid-read: no response, outputs cleared, array kept.
    xact("pre_rst", 0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3);
    step();
    issue(0, 1'b0, 16'h0010, 16'h0000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_valid", 32'(dv[0]), 32'd0);
    check("abort_data_out", 32'(dout[0]), 32'd0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dv[0]) hits++;
    end
    check("abort_no_valid", 32'(hits), 32'd0);

    // rst and enable together: request not accepted, array not written.
    rst = 1'b1;
    issue(0, 1'b1, 16'h0010, 16'h1111);
    rst = 1'b0;
    check("rst_en_busy", 32'(bsy[0]), 32'd0);
    step();
    check("rst_en_valid", 32'(dv[0]), 32'd0);
    xact("reread", 0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3);
    step();

    // Aliasing at LATENCY=4.
    xact("alias_wr", 0, 1'b1, 16'h0401, 16'h5A5A, 16'hBEEF, 3);
    step();
    xact("alias_rd", 0, 1'b0, 16'h0001, 16'h0000, 16'h5A5A, 3);
    step();

    // Aliasing at LATENCY=1: response in the cycle right after acceptance.
    xact("l1_wr", 1, 1'b1, 16'h0401, 16'h5A5A, 16'h0000, 0);
    check("l1_wr_busy", 32'(bsy[1]), 32'd0);
    step();
    check("l1_wr_gap", 32'(dv[1]), 32'd0);
    xact("l1_rd", 1, 1'b0, 16'h0001, 16'h0000, 16'h5A5A, 0);
    xact("l1_b2b", 1, 1'b0, 16'h0401, 16'h0000, 16'h5A5A, 0);
    step();
    check("l1_idle", 32'(dv[1]), 32'd0);
    check("l1_held", 32'(dout[1]), 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
